// File: rtl/seg_scan_driver_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
// Anode polarity lives here so a common-cathode variant only touches this file.
package seg_scan_driver_pkg;

  localparam int   NIBBLE_W   = 4;
  localparam int   MAX_DIGITS = 16;
  localparam logic AN_ON      = 1'b0;
  localparam logic AN_OFF     = 1'b1;

  // Bit i is set when digit i > 0 and every nibble from i upward is zero.
  // Callers zero-extend their value to MAX_DIGITS nibbles.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(
    input logic [NIBBLE_W*MAX_DIGITS-1:0] value
  );
    logic [MAX_DIGITS-1:0] mask;
    logic                  all_zero;
    mask     = '0;
    all_zero = 1'b1;
    for (int i = MAX_DIGITS - 1; i > 0; i--) begin
      all_zero = all_zero & (value[i*NIBBLE_W +: NIBBLE_W] == '0);
      mask[i]  = all_zero;
    end
    return mask;
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Load-side inputs and display-side outputs of the scan driver.
interface seg_scan_driver_if
  import seg_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  logic                           load;
  logic [NIBBLE_W*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]          blank_mask;
  logic [NUM_DIGITS-1:0]          dp_mask;
  logic [NIBBLE_W-1:0]            hex;
  logic [NUM_DIGITS-1:0]          an;
  logic                           dp;
  logic                           digit_blank;
  logic                           frame_tick;

  modport master (
    output load, value, blank_mask, dp_mask,
    input  hex, an, dp, digit_blank, frame_tick
  );

  modport slave (
    input  load, value, blank_mask, dp_mask,
    output hex, an, dp, digit_blank, frame_tick
  );

endinterface

// File: rtl/seg_scan_driver_prescaler.sv
// Slot timer: counts clk cycles within a digit slot and steps the digit index.
// Flags the dead-time window and the last cycle of each frame.
module seg_refresh_prescaler #(
  parameter  int NUM_DIGITS   = 4,
  parameter  int REFRESH_DIV  = 50000,
  parameter  int BLANK_CYCLES = 500,
  localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_in_blank,
  output logic             o_frame_boundary
);

  localparam int               CNT_W     = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             w_slot_wrap;

  assign w_slot_wrap = (r_cnt == CNT_LAST);

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_slot_wrap) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_idx            = r_idx;
  assign o_in_blank       = (r_cnt < CNT_BLANK);
  assign o_frame_boundary = w_slot_wrap && (r_idx == IDX_LAST);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment scanner with frame-aligned
// double-buffered loads, per-slot dead time and leading-zero suppression.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,     // 1..MAX_DIGITS
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int LZ_SUPPRESS  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  seg_scan_driver_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W = NIBBLE_W * NUM_DIGITS;

  typedef struct packed {
    logic [VAL_W-1:0]      value;
    logic [NUM_DIGITS-1:0] blank_mask;
    logic [NUM_DIGITS-1:0] dp_mask;
  } frame_t;

  logic [IDX_W-1:0]      w_idx;
  logic                  w_in_blank;
  logic                  w_frame_boundary;

  frame_t                w_incoming;
  frame_t                r_stage;
  frame_t                r_disp;
  logic                  r_pending;

  logic [MAX_DIGITS-1:0] w_lz_full;
  logic [NIBBLE_W-1:0]   w_nibble;
  logic                  w_suppress;
  logic                  w_dark;
  logic [NUM_DIGITS-1:0] w_an_next;
  logic                  w_dp_next;

  logic [NIBBLE_W-1:0]   r_hex;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_dp;
  logic                  r_digit_blank;
  logic                  r_frame_tick;

  seg_refresh_prescaler #(
    .NUM_DIGITS   (NUM_DIGITS),
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_prescaler (
    .clk              (clk),
    .rst_n            (rst_n),
    .o_idx            (w_idx),
    .o_in_blank       (w_in_blank),
    .o_frame_boundary (w_frame_boundary)
  );

  assign w_incoming = {bus.value, bus.blank_mask, bus.dp_mask};

  // Display only changes on a frame boundary; a load landing on the boundary
  // bypasses staging so it is not delayed by a whole frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stage   <= '0;
      r_disp    <= '0;
      r_pending <= 1'b0;
    end else if (bus.load && w_frame_boundary) begin
      r_disp    <= w_incoming;
      r_pending <= 1'b0;
    end else if (bus.load) begin
      r_stage   <= w_incoming;
      r_pending <= 1'b1;
    end else if (w_frame_boundary && r_pending) begin
      r_disp    <= r_stage;
      r_pending <= 1'b0;
    end
  end

  assign w_lz_full = lz_mask((NIBBLE_W*MAX_DIGITS)'(r_disp.value));

  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    w_nibble   = r_disp.value[int'(w_idx)*NIBBLE_W +: NIBBLE_W];
    w_suppress = r_disp.blank_mask[w_idx] | ((LZ_SUPPRESS != 0) && w_lz_full[w_idx]);
    w_dark     = w_in_blank | w_suppress;
    w_an_next  = {NUM_DIGITS{AN_OFF}};
    w_dp_next  = 1'b1;
    if (!w_dark) begin
      w_an_next[w_idx] = AN_ON;
      w_dp_next        = ~r_disp.dp_mask[w_idx];
    end
  end

  // Registered outputs keep the pad drivers glitch-free as idx/cnt roll over.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hex         <= '0;
      r_an          <= {NUM_DIGITS{AN_OFF}};
      r_dp          <= 1'b1;
      r_digit_blank <= 1'b1;
      r_frame_tick  <= 1'b0;
    end else begin
      r_hex         <= w_nibble;
      r_an          <= w_an_next;
      r_dp          <= w_dp_next;
      r_digit_blank <= w_dark;
      r_frame_tick  <= w_frame_boundary;
    end
  end

  assign bus.hex         = r_hex;
  assign bus.an          = r_an;
  assign bus.dp          = r_dp;
  assign bus.digit_blank = r_digit_blank;
  assign bus.frame_tick  = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: per-cycle scoreboard against a behavioural model,
// a table of display patterns, and directed load-timing / reset sequences.
module tb_seg_scan_driver;
  import seg_scan_driver_pkg::*;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg_scan_driver_if #(.NUM_DIGITS(ND)) bus_lz ();
  seg_scan_driver_if #(.NUM_DIGITS(ND)) bus_nz ();

  seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZ_SUPPRESS(1))
    dut_lz (.clk(clk), .rst_n(rst_n), .bus(bus_lz));
  seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZ_SUPPRESS(0))
    dut_nz (.clk(clk), .rst_n(rst_n), .bus(bus_nz));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard: {hex, an, dp, digit_blank, frame_tick}
  typedef logic [10:0] obs_t;
  localparam obs_t OBS_RESET = {4'h0, 4'hF, 1'b1, 1'b1, 1'b0};

  obs_t        q_lz[$];
  obs_t        q_nz[$];
  int          m_t;
  logic        m_pend;
  logic [15:0] m_sval, m_dval;
  logic [3:0]  m_sblk, m_dblk, m_sdp, m_ddp;

  // Model time m_t is cycles since reset modulo one frame.
  function automatic obs_t expect_out(input bit lz);
    int         cnt, idx;
    logic       dark;
    logic [3:0] an;
    cnt  = m_t % RD;
    idx  = (m_t / RD) % ND;
    dark = (cnt < BC) || m_dblk[idx] || (lz && idx > 0 && (m_dval >> (4*idx)) == 16'h0);
    an   = 4'hF;
    if (!dark) an[idx] = 1'b0;
    return {m_dval[4*idx +: 4], an, dark ? 1'b1 : ~m_ddp[idx], dark,
            (cnt == RD-1) && (idx == ND-1)};
  endfunction

  always @(posedge clk) begin : model
    bit fb;
    if (!rst_n) begin
      q_lz.push_back(OBS_RESET);
      q_nz.push_back(OBS_RESET);
      m_t    <= 0;
      m_pend <= 1'b0;
      m_sval <= '0; m_sblk <= '0; m_sdp <= '0;
      m_dval <= '0; m_dblk <= '0; m_ddp <= '0;
    end else begin
      q_lz.push_back(expect_out(1'b1));
      q_nz.push_back(expect_out(1'b0));
      fb = (m_t == RD*ND - 1);
      if (bus_lz.load && fb) begin
        m_dval <= bus_lz.value; m_dblk <= bus_lz.blank_mask; m_ddp <= bus_lz.dp_mask;
        m_pend <= 1'b0;
      end else if (bus_lz.load) begin
        m_sval <= bus_lz.value; m_sblk <= bus_lz.blank_mask; m_sdp <= bus_lz.dp_mask;
        m_pend <= 1'b1;
      end else if (fb && m_pend) begin
        m_dval <= m_sval; m_dblk <= m_sblk; m_ddp <= m_sdp;
        m_pend <= 1'b0;
      end
      m_t <= (m_t + 1) % (RD*ND);
    end
  end

  always @(negedge clk) begin : scoreboard
    obs_t e;
    if (q_lz.size() > 0) begin
      e = q_lz.pop_front();
      check("sb_lz", 32'({bus_lz.hex, bus_lz.an, bus_lz.dp, bus_lz.digit_blank, bus_lz.frame_tick}), 32'(e));
    end
    if (q_nz.size() > 0) begin
      e = q_nz.pop_front();
      check("sb_nz", 32'({bus_nz.hex, bus_nz.an, bus_nz.dp, bus_nz.digit_blank, bus_nz.frame_tick}), 32'(e));
    end
  end

  // ---------------- stimulus helpers
  task automatic set_inputs(input logic ld, input logic [15:0] v, input logic [3:0] b, input logic [3:0] d);
    bus_lz.load = ld; bus_lz.value = v; bus_lz.blank_mask = b; bus_lz.dp_mask = d;
    bus_nz.load = ld; bus_nz.value = v; bus_nz.blank_mask = b; bus_nz.dp_mask = d;
  endtask

  // Called at a rising edge; load is sampled by the following edge.
  task automatic do_load(input logic [15:0] v, input logic [3:0] b, input logic [3:0] d);
    #1 set_inputs(1'b1, v, b, d);
    @(posedge clk);
    #1 set_inputs(1'b0, v, b, d);
  endtask

  // Returns at the falling edge where frame_tick is high.
  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus_lz.frame_tick !== 1'b1 && n < 100);
    check("frame_tick_seen", 32'(bus_lz.frame_tick), 32'd1);
  endtask

  // Watches one full frame starting right after a frame_tick.
  task automatic observe_frame(input bit sel, input logic [15:0] ev, input logic [3:0] elit,
                               input logic [3:0] edp, input string tag);
    logic [3:0] lit, dpo, an, hx;
    logic       d, db;
    int         cnt[4];
    int         viol;
    int         slot, pos;
    lit = '0; dpo = '0; viol = 0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int k = 0; k < RD*ND; k++) begin
      @(negedge clk);
      if (sel) begin an = bus_nz.an; hx = bus_nz.hex; d = bus_nz.dp; db = bus_nz.digit_blank; end
      else     begin an = bus_lz.an; hx = bus_lz.hex; d = bus_lz.dp; db = bus_lz.digit_blank; end
      slot = k / RD;
      pos  = k % RD;
      lit |= ~an;
      if (!d) dpo[slot] = 1'b1;
      if (!an[slot]) cnt[slot]++;
      if ((pos < BC && an != 4'hF) || (an != 4'hF && an != ~(4'b0001 << slot)) ||
          (!d && an[slot]) || (db != (an == 4'hF)))
        viol++;
      if (pos == 4) check({tag, "_hex"}, 32'(hx), 32'(ev[4*slot +: 4]));
    end
    check({tag, "_lit"}, 32'(lit), 32'(elit));
    check({tag, "_dp"}, 32'(dpo), 32'(edp));
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_litcycles%0d", tag, i), 32'(cnt[i]), elit[i] ? 32'(RD-BC) : 32'd0);
    check({tag, "_viol"}, 32'(viol), 32'd0);
  endtask

  // ---------------- pattern table
  typedef struct {
    logic [15:0] value;
    logic [3:0]  blank;
    logic [3:0]  dpm;
    bit          sel_nz;
    logic [3:0]  exp_lit;
    logic [3:0]  exp_dp;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  initial begin : main
    int edges;
    vecs[0] = '{16'h12A3, 4'b0000, 4'b0100, 1'b0, 4'b1111, 4'b0100};
    vecs[1] = '{16'h0040, 4'b0000, 4'b0000, 1'b0, 4'b0011, 4'b0000};
    vecs[2] = '{16'h0000, 4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0000};
    vecs[3] = '{16'h1111, 4'b0010, 4'b0000, 1'b0, 4'b1101, 4'b0000};
    vecs[4] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 4'b1111, 4'b0000};
    vecs[5] = '{16'h0105, 4'b0000, 4'b1001, 1'b0, 4'b0111, 4'b0001};
    vecs[6] = '{16'hF00E, 4'b0001, 4'b1111, 1'b0, 4'b1110, 4'b1110};

    rst_n = 1'b0;
    set_inputs(1'b0, 16'h0, 4'h0, 4'h0);

    // Reset: outputs dark for both reset cycles and the first running one.
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_an", 32'(bus_lz.an), 32'hF);
      check("rst_dp", 32'(bus_lz.dp), 32'd1);
      check("rst_blank", 32'(bus_lz.digit_blank), 32'd1);
      check("rst_tick", 32'(bus_lz.frame_tick), 32'd0);
      check("rst_hex", 32'(bus_lz.hex), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_an", 32'(bus_lz.an), 32'hF);
    check("post_rst_blank", 32'(bus_lz.digit_blank), 32'd1);
    edges = 1;
    while (bus_lz.frame_tick !== 1'b1 && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    // Tick is visible in the 33rd cycle after release, i.e. after 32 edges.
    check("first_tick_edges", 32'(edges), 32'd32);

    // Table: load during slot 1, expect the pattern in the following frame.
    for (int v = 0; v < NV; v++) begin
      wait_tick();
      repeat (10) @(posedge clk);
      do_load(vecs[v].value, vecs[v].blank, vecs[v].dpm);
      wait_tick();
      observe_frame(vecs[v].sel_nz, vecs[v].value, vecs[v].exp_lit, vecs[v].exp_dp,
                    $sformatf("vec%0d", v));
    end

    // Load coinciding with the boundary shows in the frame it starts.
    wait_tick();
    repeat (RD*ND - 1) @(posedge clk);
    do_load(16'h7654, 4'b0000, 4'b0000);
    wait_tick();
    observe_frame(1'b0, 16'h7654, 4'b1111, 4'b0000, "boundary_load");

    // Two loads in one frame: the second replaces the first.
    wait_tick();
    repeat (3) @(posedge clk);
    do_load(16'hAAAA, 4'b0000, 4'b0000);
    repeat (5) @(posedge clk);
    do_load(16'hBBBB, 4'b0000, 4'b0000);
    wait_tick();
    observe_frame(1'b0, 16'hBBBB, 4'b1111, 4'b0000, "last_wins");

    // Reset during slot 2 with a load pending discards it.
    wait_tick();
    repeat (18) @(posedge clk);
    do_load(16'h9999, 4'b0000, 4'b1111);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_an", 32'(bus_lz.an), 32'hF);
    check("midrst_hex", 32'(bus_lz.hex), 32'd0);
    check("midrst_tick", 32'(bus_lz.frame_tick), 32'd0);
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
    end while (bus_lz.frame_tick !== 1'b1 && edges < 100);
    check("midrst_tick_edges", 32'(edges), 32'd32);
    observe_frame(1'b0, 16'h0000, 4'b0001, 4'b0000, "midrst_frame");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed scanner for an N-digit common-anode seven-segment display.
- Holds a multi-digit hex value and selects one digit per refresh slot.
- Presents that digit's 4-bit nibble to the downstream hex-to-segment decoder and drives the active-low anode and decimal-point lines.
- Double-buffers loads so a new value only appears at a frame boundary, which avoids tearing. Inserts a dead time at each slot start to suppress ghosting.

Parameters:
- NUM_DIGITS, 4: number of digits scanned. Must be >= 1.
- REFRESH_DIV, 50000: clk cycles per digit slot. Must be >= 2.
- BLANK_CYCLES, 500: dead-time cycles at the start of each slot, with all anodes off. Must be < REFRESH_DIV.
- LZ_SUPPRESS, 1: 1 enables leading-zero suppression.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- load  in  1  one-cycle strobe that captures value, blank_mask and dp_mask
- value  in  4*NUM_DIGITS  hex digits; nibble i is digit i, and digit 0 is the rightmost
- blank_mask  in  NUM_DIGITS  1 forces digit i dark
- dp_mask  in  NUM_DIGITS  1 lights the decimal point of digit i
- hex  out  4  nibble for the current slot, fed to the downstream decoder
- an  out  NUM_DIGITS  anode selects, active low
- dp  out  1  decimal point, active low
- digit_blank  out  1  1 means the downstream decoder output must be forced off
- frame_tick  out  1  one-cycle pulse at the start of each frame

Behaviour:
- Reset is synchronous and active-low. On a clk edge with rst_n=0:
  - State: prescaler cnt=0, digit index idx=0, staging registers=0, display registers=0, pending=0.
  - Outputs: an=all 1, hex=0, dp=1, digit_blank=1, frame_tick=0.
- Reset asserted mid-operation has the same effect at the next edge. Any pending load is discarded.
- Prescaler:
  - Width is $clog2(REFRESH_DIV).
  - cnt counts 0..REFRESH_DIV-1 and wraps to 0.
  - On wrap, idx advances by 1 modulo NUM_DIGITS, so NUM_DIGITS-1 goes to 0.
- Frame boundary: the cycle in which cnt wraps and idx goes from NUM_DIGITS-1 to 0.
- Load handling:
  - load=1 captures value, blank_mask and dp_mask into staging and sets pending=1.
  - At a frame boundary with pending=1, staging is copied to display and pending clears.
  - If load coincides with a frame boundary, the incoming inputs go directly to display and pending stays 0.
  - Multiple loads within one frame: the last one wins.
- Output timing: all outputs are registered. They reflect (idx, cnt, display) with 1-cycle latency.
- Within a slot:
  - hex = display nibble[idx] for the whole slot.
  - While cnt < BLANK_CYCLES: an = all 1, dp = 1, digit_blank = 1.
  - Otherwise: an[idx] = 0 and other anodes = 1, dp = ~dp_mask[idx], digit_blank = 0, unless the digit is suppressed.
- A digit is suppressed when either holds:
  - blank_mask[idx]=1, or
  - LZ_SUPPRESS=1, idx>0, and display nibbles idx..NUM_DIGITS-1 are all zero.
- Digit 0 is never zero-suppressed.
- A suppressed digit gives an all 1, dp=1 and digit_blank=1 for its entire slot.
- frame_tick = 1 for exactly the one cycle after each frame boundary.

Decomposition:
- Shared display package holds:
  - the digit-nibble width constant (4);
  - the active-low anode on/off constants;
  - a function computing the leading-zero mask from a value vector.
- One sub-module is natural: seg_refresh_prescaler. It contains the cnt counter, the slot-wrap strobe and the idx counter, and outputs idx, the in_blank flag and the frame_boundary strobe.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2 and LZ_SUPPRESS=1 unless stated otherwise.
1. Reset: rst_n=0 for 2 cycles, then released.
   - During reset and the following cycle: an=4'b1111, dp=1, digit_blank=1, frame_tick=0.
   - First frame_tick occurs 33 cycles after release.
2. Load mid-frame: load value=16'h12A3, dp_mask=4'b0100 while idx=1.
   - The display stays 0 until the next boundary.
   - In the next frame, slots show hex 3, A, 2, 1 with an 1110, 1101, 1011, 0111.
   - Each slot has 2 dark cycles followed by 6 lit cycles.
   - dp=0 only in the lit cycles of digit 2.
3. Leading zeros:
   - value=16'h0040: digits 3 and 2 stay dark (an never low), digit 1 shows 4, digit 0 shows 0.
   - value=16'h0000: only an[0] goes low.
   - With LZ_SUPPRESS=0 and value=16'h0000: all four digits light.
4. Blank mask: blank_mask=4'b0010 with value=16'h1111.
   - an[1] never goes low.
   - digit_blank=1 for the whole of slot 1.
   - Digits 0, 2 and 3 light normally.
5. Load timing:
   - load coinciding with the frame-boundary cycle takes effect in that same frame.
   - Loads of 16'hAAAA then 16'hBBBB within one frame: only BBBB is ever displayed.
6. Reset mid-operation: rst_n=0 for one edge mid-slot 2 while a load is pending.
   - At the next edge: an=1111, idx=0, and the pending value is never displayed.
   - The display shows 0 after release.
